// File: rtl/traffic_lcd_writer.sv
// HD44780 16x2 writer: power-on init, then endless two-line refresh of time and signal phase.
// Each frame's 32 characters come from one input snapshot, so the display never shows a torn value.
module traffic_lcd_writer #(
    parameter int PWR_CYCLES  = 40,
    parameter int SLOT_CYCLES = 4,
    parameter int CLEAR_WAIT  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic [3:0] state,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    localparam int CNT_W = 16;

    typedef enum logic [3:0] {
        S_PWR_WAIT,
        S_FUNC_SET,
        S_DISP_ON,
        S_ENTRY,
        S_CLEAR,
        S_CLR_WAIT,
        S_L1_ADDR,
        S_L1_CHAR,
        S_L2_ADDR,
        S_L2_CHAR
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic [4:0]       snap_h_q;
    logic [5:0]       snap_m_q, snap_s_q;
    logic [3:0]       snap_st_q;
    logic             slot_end;
    logic             is_slot;

    function automatic logic [15:0] two_digit(input logic [5:0] v, input logic [5:0] limit);
        logic [5:0] tens;
        logic [5:0] ones;
        if (v >= limit) begin
            two_digit = 16'h3F3F;
        end else begin
            tens      = v / 6'd10;
            ones      = v - tens * 6'd10;
            two_digit = {8'h30 + {2'b00, tens}, 8'h30 + {2'b00, ones}};
        end
    endfunction

    function automatic logic [15:0] phase_label(input logic [3:0] st);
        case (st)
            4'd0:    phase_label = "A ";
            4'd1:    phase_label = "B ";
            4'd2:    phase_label = "C ";
            4'd3:    phase_label = "D ";
            4'd4:    phase_label = "E ";
            4'd5:    phase_label = "F ";
            4'd6:    phase_label = "G ";
            4'd7:    phase_label = "H ";
            4'd8:    phase_label = "A1";
            4'd9:    phase_label = "A2";
            4'd10:   phase_label = "B1";
            4'd11:   phase_label = "C1";
            4'd12:   phase_label = "E1";
            4'd13:   phase_label = "E2";
            4'd14:   phase_label = "F1";
            default: phase_label = "G1";
        endcase
    endfunction

    function automatic logic [7:0] line1_char(input logic [3:0] idx, input logic [4:0] h,
                                              input logic [5:0] m, input logic [5:0] s);
        logic [15:0] hh;
        logic [15:0] mm;
        logic [15:0] ss;
        hh = two_digit({1'b0, h}, 6'd24);
        mm = two_digit(m, 6'd60);
        ss = two_digit(s, 6'd60);
        case (idx)
            4'd0:    line1_char = "T";
            4'd1:    line1_char = "I";
            4'd2:    line1_char = "M";
            4'd3:    line1_char = "E";
            4'd5:    line1_char = hh[15:8];
            4'd6:    line1_char = hh[7:0];
            4'd7:    line1_char = ":";
            4'd8:    line1_char = mm[15:8];
            4'd9:    line1_char = mm[7:0];
            4'd10:   line1_char = ":";
            4'd11:   line1_char = ss[15:8];
            4'd12:   line1_char = ss[7:0];
            default: line1_char = " ";
        endcase
    endfunction

    function automatic logic [7:0] line2_char(input logic [3:0] idx, input logic [4:0] h,
                                              input logic [3:0] st);
        logic [15:0] lab;
        logic [23:0] mode;
        lab  = phase_label(st);
        // Day runs 08:00 up to but not including 23:00; any invalid hour reads as night.
        mode = (h >= 5'd8 && h < 5'd23) ? "DAY" : "NGT";
        case (idx)
            4'd0:    line2_char = "S";
            4'd1:    line2_char = "T";
            4'd2:    line2_char = ":";
            4'd3:    line2_char = lab[15:8];
            4'd4:    line2_char = lab[7:0];
            4'd7:    line2_char = mode[23:16];
            4'd8:    line2_char = mode[15:8];
            4'd9:    line2_char = mode[7:0];
            default: line2_char = " ";
        endcase
    endfunction

    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        slot_end = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
        case (fsm_q)
            S_PWR_WAIT: if (cnt_q == CNT_W'(PWR_CYCLES - 1)) begin
                fsm_d = S_FUNC_SET;
                cnt_d = '0;
            end
            S_FUNC_SET: if (slot_end) begin fsm_d = S_DISP_ON; cnt_d = '0; end
            S_DISP_ON:  if (slot_end) begin fsm_d = S_ENTRY;   cnt_d = '0; end
            S_ENTRY:    if (slot_end) begin fsm_d = S_CLEAR;   cnt_d = '0; end
            S_CLEAR: if (slot_end) begin
                fsm_d = (CLEAR_WAIT == 0) ? S_L1_ADDR : S_CLR_WAIT;
                cnt_d = '0;
                idx_d = '0;
            end
            S_CLR_WAIT: if (cnt_q == CNT_W'(CLEAR_WAIT - 1)) begin
                fsm_d = S_L1_ADDR;
                cnt_d = '0;
                idx_d = '0;
            end
            S_L1_ADDR: if (slot_end) begin fsm_d = S_L1_CHAR; cnt_d = '0; idx_d = '0; end
            S_L1_CHAR: if (slot_end) begin
                cnt_d = '0;
                if (idx_q == 4'd15) begin
                    fsm_d = S_L2_ADDR;
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_L2_ADDR: if (slot_end) begin fsm_d = S_L2_CHAR; cnt_d = '0; idx_d = '0; end
            S_L2_CHAR: if (slot_end) begin
                cnt_d = '0;
                if (idx_q == 4'd15) begin
                    fsm_d = S_L1_ADDR;
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: begin
                fsm_d = S_PWR_WAIT;
                cnt_d = '0;
                idx_d = '0;
            end
        endcase

        // Outputs are registered from next-state so RS/DATA change exactly at slot start.
        rs_d    = rs_q;
        data_d  = data_q;
        is_slot = (fsm_d != S_PWR_WAIT) && (fsm_d != S_CLR_WAIT);
        e_d     = is_slot && (cnt_d == CNT_W'(1));
        if (is_slot && cnt_d == '0) begin
            case (fsm_d)
                S_FUNC_SET: begin rs_d = 1'b0; data_d = 8'h38; end
                S_DISP_ON:  begin rs_d = 1'b0; data_d = 8'h0C; end
                S_ENTRY:    begin rs_d = 1'b0; data_d = 8'h06; end
                S_CLEAR:    begin rs_d = 1'b0; data_d = 8'h01; end
                S_L1_ADDR:  begin rs_d = 1'b0; data_d = 8'h80; end
                S_L2_ADDR:  begin rs_d = 1'b0; data_d = 8'hC0; end
                S_L1_CHAR: begin
                    rs_d   = 1'b1;
                    data_d = line1_char(idx_d, snap_h_q, snap_m_q, snap_s_q);
                end
                S_L2_CHAR: begin
                    rs_d   = 1'b1;
                    data_d = line2_char(idx_d, snap_h_q, snap_st_q);
                end
                default: begin rs_d = rs_q; data_d = data_q; end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q     <= S_PWR_WAIT;
            cnt_q     <= '0;
            idx_q     <= '0;
            e_q       <= 1'b0;
            rs_q      <= 1'b0;
            data_q    <= 8'h00;
            snap_h_q  <= '0;
            snap_m_q  <= '0;
            snap_s_q  <= '0;
            snap_st_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            e_q    <= e_d;
            rs_q   <= rs_d;
            data_q <= data_d;
            if (fsm_q == S_L1_ADDR && cnt_q == '0) begin
                snap_h_q  <= hour;
                snap_m_q  <= minute;
                snap_s_q  <= second;
                snap_st_q <= state;
            end
        end
    end

    assign LCD_E    = e_q;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;
    assign LCD_DATA = data_q;

endmodule
